// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage: load encodings,
// controller states and the WB pipeline register layout.
package wb_pkg;

  localparam int WB_XLEN = 32;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LBU = 3'd1,
    LD_LH  = 3'd2,
    LD_LHU = 3'd3,
    LD_LW  = 3'd4
  } ld_type_e;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic               valid;
    logic               wreg;
    logic [4:0]         waddr;
    logic [WB_XLEN-1:0] wdata;
    logic               load;
    logic [2:0]         ld_type;
    logic [1:0]         addr_lo;
    logic               exc;
  } wb_reg_t;

  // Encodings above LW behave as LW, so they need a word-aligned address.
  function automatic logic load_misaligned(input logic [2:0] ld_type,
                                           input logic [1:0] addr_lo);
    logic mis;
    case (ld_type)
      LD_LB, LD_LBU: mis = 1'b0;
      LD_LH, LD_LHU: mis = addr_lo[0];
      default:       mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/wb_ctrl_load_align.sv
// Selects the addressed byte/halfword of a 32-bit read word and extends it
// to full width according to the load type.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        ld_type,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (ld_type)
      LD_LB:   aligned = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_LBU:  aligned = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_LH:   aligned = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_LHU:  aligned = {{(DATA_W-16){1'b0}}, half_sel};
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller: registers the MEM result, waits for D-cache load
// data, drives the register file write port and counts load-miss cycles.
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              mem_valid,
  input  logic              mem_wreg,
  input  logic [4:0]        mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_load,
  input  logic [2:0]        mem_ld_type,
  input  logic [1:0]        mem_addr_lo,
  input  logic              dc_rvalid,
  input  logic [DATA_W-1:0] dc_rdata,
  output logic              we,
  output logic [4:0]        waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wb_stall,
  output logic              adel_exc,
  output logic [CNT_W-1:0]  miss_cycles
);

  wb_state_e         state_q, state_d;
  wb_reg_t           wbr_q, wbr_d, mem_entry;
  logic [4:0]        hold_waddr_q, hold_waddr_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
  logic [CNT_W-1:0]  miss_q, miss_d;
  logic [DATA_W-1:0] ld_aligned;
  logic              capture;
  logic              wait_done;
  logic              enter_wait;
  logic              issue_alu;
  logic              issue_ld;
  logic              issue;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .rdata   (dc_rdata),
    .ld_type (wbr_q.ld_type),
    .addr_lo (wbr_q.addr_lo),
    .aligned (ld_aligned)
  );

  always_comb begin
    mem_entry         = '0;
    mem_entry.valid   = mem_valid;
    mem_entry.wreg    = mem_wreg;
    mem_entry.waddr   = mem_waddr;
    mem_entry.wdata   = mem_wdata;
    mem_entry.load    = mem_load;
    mem_entry.ld_type = mem_ld_type;
    mem_entry.addr_lo = mem_addr_lo;
    mem_entry.exc     = mem_valid & mem_load & load_misaligned(mem_ld_type, mem_addr_lo);
  end

  // A completing WAIT frees the register on the same edge it returns to IDLE.
  assign wait_done  = (state_q == WB_WAIT) && dc_rvalid;
  assign capture    = !stall_in && ((state_q == WB_IDLE) || wait_done);
  assign enter_wait = mem_entry.valid && mem_entry.load && !mem_entry.exc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE: begin
        if (capture && enter_wait) state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (wait_done) state_d = (capture && enter_wait) ? WB_WAIT : WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // A finished load that cannot be replaced (stall_in high) becomes a bubble
  // so that IDLE never replays it.
  always_comb begin
    wbr_d = wbr_q;
    if (capture) begin
      wbr_d = mem_entry;
    end else if (wait_done) begin
      wbr_d.valid = 1'b0;
    end
  end

  always_comb begin
    issue_alu = (state_q == WB_IDLE) && wbr_q.valid && wbr_q.wreg &&
                !wbr_q.load && !wbr_q.exc && !stall_in;
    issue_ld  = wait_done && wbr_q.wreg;
    issue     = issue_alu || issue_ld;

    hold_waddr_d = hold_waddr_q;
    hold_wdata_d = hold_wdata_q;
    if (issue_ld) begin
      hold_waddr_d = wbr_q.waddr;
      hold_wdata_d = ld_aligned;
    end else if (issue_alu) begin
      hold_waddr_d = wbr_q.waddr;
      hold_wdata_d = wbr_q.wdata;
    end

    miss_d = miss_q;
    if ((state_q == WB_WAIT) && !dc_rvalid) miss_d = sat_inc(miss_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbr_q        <= '0;
      hold_waddr_q <= '0;
      hold_wdata_q <= '0;
      miss_q       <= '0;
    end else begin
      wbr_q        <= wbr_d;
      hold_waddr_q <= hold_waddr_d;
      hold_wdata_q <= hold_wdata_d;
      miss_q       <= miss_d;
    end
  end

  // Write-port values pass straight through on an issuing cycle and are
  // otherwise held, which keeps waddr/wdata stable while we is low.
  always_comb begin
    we          = issue && (wbr_q.waddr != REG_ZERO);
    waddr       = hold_waddr_d;
    wdata       = hold_wdata_d;
    wb_stall    = (state_q == WB_WAIT) && !dc_rvalid;
    adel_exc    = (state_q == WB_IDLE) && wbr_q.valid && wbr_q.exc && !stall_in;
    miss_cycles = miss_q;
  end

endmodule
